// File: rtl/ship_board.sv
// ship_board -- board-state store for one player's fleet.
//
// Records single-cell ships during the picking phase and resolves incoming
// shots during play. It also serves a registered read port to the VGA draw
// stage.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   pick_ship     placement phase enable from the control logic
//   place_req     single-cycle placement strobe for cell_pos
//   cell_pos      placement cell, [7:4] row, [3:0] column
//   shot_valid    single-cycle incoming shot strobe for shot_pos
//   shot_pos      shot cell, [7:4] row, [3:0] column
//   rd_pos        draw-stage read cell, [7:4] row, [3:0] column
//   ship_count    ships placed so far
//   board_full    ship_count == SHIPS
//   place_err     one-cycle pulse, placement rejected
//   shot_done     one-cycle pulse, shot resolved
//   shot_hit      with shot_done: fresh hit on a ship
//   shot_repeat   with shot_done: cell had already been shot
//   all_sunk      every ship has been hit
//   rd_ship       read data: ship present at rd_pos (1-cycle latency)
//   rd_shot       read data: cell at rd_pos has been shot (1-cycle latency)
module ship_board #(
    parameter int GRID  = 10,
    parameter int SHIPS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pick_ship,
    input  logic       place_req,
    input  logic [7:0] cell_pos,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    input  logic [7:0] rd_pos,
    output logic [3:0] ship_count,
    output logic       board_full,
    output logic       place_err,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_repeat,
    output logic       all_sunk,
    output logic       rd_ship,
    output logic       rd_shot
);

    localparam int         IDX_W   = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [3:0] GRID_L  = 4'(GRID);
    localparam logic [3:0] SHIPS_L = 4'(SHIPS);

    typedef enum logic [1:0] {SETUP, PLAY, SUNK} state_t;

    state_t                       r_state;
    logic [GRID-1:0][GRID-1:0]    r_ship_map;
    logic [GRID-1:0][GRID-1:0]    r_shot_map;
    logic [3:0]                   r_ship_count;
    logic [3:0]                   r_hit_count;
    logic                         r_place_err;
    logic                         r_shot_done;
    logic                         r_shot_hit;
    logic                         r_shot_repeat;
    logic                         r_rd_ship;
    logic                         r_rd_shot;

    function automatic logic in_range(input logic [7:0] pos);
        return (pos[7:4] < GRID_L) && (pos[3:0] < GRID_L);
    endfunction

    // Out-of-range cells read as empty; the guard also keeps the index legal.
    function automatic logic map_bit(input logic [GRID-1:0][GRID-1:0] m,
                                     input logic [7:0] pos);
        logic [3:0] row;
        logic [3:0] col;
        row = pos[7:4];
        col = pos[3:0];
        map_bit = 1'b0;
        if (in_range(pos))
            map_bit = m[row[IDX_W-1:0]][col[IDX_W-1:0]];
    endfunction

    logic             w_place_ok;
    logic             w_shot_live;
    logic             w_sh_ship;
    logic             w_sh_shot;
    logic             w_shot_hit;
    logic [IDX_W-1:0] w_pl_r;
    logic [IDX_W-1:0] w_pl_c;
    logic [IDX_W-1:0] w_sh_r;
    logic [IDX_W-1:0] w_sh_c;

    assign w_pl_r = cell_pos[4 +: IDX_W];
    assign w_pl_c = cell_pos[0 +: IDX_W];
    assign w_sh_r = shot_pos[4 +: IDX_W];
    assign w_sh_c = shot_pos[0 +: IDX_W];

    assign w_place_ok = place_req && pick_ship && (r_state == SETUP)
                        && in_range(cell_pos) && !map_bit(r_ship_map, cell_pos)
                        && (r_ship_count < SHIPS_L);

    // Shots are only acted on outside SETUP, so they never race a placement.
    assign w_shot_live = shot_valid && (r_state != SETUP) && in_range(shot_pos);
    assign w_sh_ship   = map_bit(r_ship_map, shot_pos);
    assign w_sh_shot   = map_bit(r_shot_map, shot_pos);
    assign w_shot_hit  = w_shot_live && w_sh_ship && !w_sh_shot;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SETUP;
            // NOTE: the maps are plain flops, not RAM, so they can be cleared
            // in a single cycle; a new game must start on an empty board.
            r_ship_map    <= '0;
            r_shot_map    <= '0;
            r_ship_count  <= '0;
            r_hit_count   <= '0;
            r_place_err   <= 1'b0;
            r_shot_done   <= 1'b0;
            r_shot_hit    <= 1'b0;
            r_shot_repeat <= 1'b0;
            r_rd_ship     <= 1'b0;
            r_rd_shot     <= 1'b0;
        end else begin
            case (r_state)
                SETUP:   if (r_ship_count == SHIPS_L) r_state <= PLAY;
                PLAY:    if (r_hit_count == SHIPS_L)  r_state <= SUNK;
                SUNK:    r_state <= SUNK;
                default: r_state <= SETUP;
            endcase

            // Placement: silently ignored while pick_ship is low.
            r_place_err <= place_req && pick_ship && !w_place_ok;
            if (w_place_ok) begin
                r_ship_map[w_pl_r][w_pl_c] <= 1'b1;
                r_ship_count               <= r_ship_count + 4'd1;
            end

            // Every strobe is acknowledged; only live shots touch the map.
            r_shot_done   <= shot_valid;
            r_shot_hit    <= w_shot_hit;
            r_shot_repeat <= w_shot_live && w_sh_shot;
            if (w_shot_live) begin
                r_shot_map[w_sh_r][w_sh_c] <= 1'b1;
                if (w_shot_hit && (r_hit_count < SHIPS_L))
                    r_hit_count <= r_hit_count + 4'd1;
            end

            r_rd_ship <= map_bit(r_ship_map, rd_pos);
            r_rd_shot <= map_bit(r_shot_map, rd_pos);
        end
    end

    assign ship_count  = r_ship_count;
    assign board_full  = (r_ship_count == SHIPS_L);
    assign all_sunk    = (r_hit_count == SHIPS_L);
    assign place_err   = r_place_err;
    assign shot_done   = r_shot_done;
    assign shot_hit    = r_shot_hit;
    assign shot_repeat = r_shot_repeat;
    assign rd_ship     = r_rd_ship;
    assign rd_shot     = r_rd_shot;

endmodule

// File: tb/tb_ship_board.sv
// tb_ship_board -- directed self-checking bench for ship_board.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each check sees the result of the edge just passed.
module tb_ship_board;

    logic       clk;
    logic       rst;
    logic       pick_ship;
    logic       place_req;
    logic [7:0] cell_pos;
    logic       shot_valid;
    logic [7:0] shot_pos;
    logic [7:0] rd_pos;
    logic [3:0] ship_count;
    logic       board_full;
    logic       place_err;
    logic       shot_done;
    logic       shot_hit;
    logic       shot_repeat;
    logic       all_sunk;
    logic       rd_ship;
    logic       rd_shot;

    int checks = 0;
    int errors = 0;

    ship_board #(.GRID(10), .SHIPS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .pick_ship  (pick_ship),
        .place_req  (place_req),
        .cell_pos   (cell_pos),
        .shot_valid (shot_valid),
        .shot_pos   (shot_pos),
        .rd_pos     (rd_pos),
        .ship_count (ship_count),
        .board_full (board_full),
        .place_err  (place_err),
        .shot_done  (shot_done),
        .shot_hit   (shot_hit),
        .shot_repeat(shot_repeat),
        .all_sunk   (all_sunk),
        .rd_ship    (rd_ship),
        .rd_shot    (rd_shot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_shot(input string tag, input logic done, input logic hit, input logic rep);
        check({tag, ".done"}, {7'd0, shot_done}, {7'd0, done});
        check({tag, ".hit"},  {7'd0, shot_hit},  {7'd0, hit});
        check({tag, ".rep"},  {7'd0, shot_repeat}, {7'd0, rep});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".count"}, {4'd0, ship_count}, 8'd0);
        check({tag, ".full"},  {7'd0, board_full}, 8'd0);
        check({tag, ".perr"},  {7'd0, place_err},  8'd0);
        check_shot(tag, 1'b0, 1'b0, 1'b0);
        check({tag, ".sunk"},  {7'd0, all_sunk},   8'd0);
        check({tag, ".rship"}, {7'd0, rd_ship},    8'd0);
        check({tag, ".rshot"}, {7'd0, rd_shot},    8'd0);
    endtask

    task automatic place(input logic [7:0] pos);
        place_req = 1'b1;
        cell_pos  = pos;
        cyc();
        place_req = 1'b0;
    endtask

    task automatic shoot(input logic [7:0] pos);
        shot_valid = 1'b1;
        shot_pos   = pos;
        cyc();
        shot_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] pos, input logic ship, input logic shot, input string tag);
        rd_pos = pos;
        cyc();
        check({tag, ".rship"}, {7'd0, rd_ship}, {7'd0, ship});
        check({tag, ".rshot"}, {7'd0, rd_shot}, {7'd0, shot});
    endtask

    initial begin
        logic [7:0] remaining [9];
        remaining = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09};

        rst = 1'b1; pick_ship = 1'b0; place_req = 1'b0; cell_pos = 8'h00;
        shot_valid = 1'b0; shot_pos = 8'h00; rd_pos = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Fill the board 0x00..0x09 in consecutive cycles.
        pick_ship = 1'b1;
        for (int i = 0; i < 10; i++) begin
            place(8'(i));
            check($sformatf("fill%0d.count", i), {4'd0, ship_count}, 8'(i + 1));
            check($sformatf("fill%0d.perr", i),  {7'd0, place_err}, 8'd0);
            check($sformatf("fill%0d.full", i),  {7'd0, board_full}, (i == 9) ? 8'd1 : 8'd0);
        end

        // 11th placement while full is rejected (state still SETUP this cycle).
        place(8'h23);
        check("over.perr",  {7'd0, place_err}, 8'd1);
        check("over.count", {4'd0, ship_count}, 8'd10);

        // pick_ship low: ignored without error.
        pick_ship = 1'b0;
        place(8'h33);
        check("nopick.perr",  {7'd0, place_err}, 8'd0);
        check("nopick.count", {4'd0, ship_count}, 8'd10);

        // Play: hit, repeat, miss.
        shoot(8'h05);
        check_shot("hit05", 1'b1, 1'b1, 1'b0);
        shoot(8'h05);
        check_shot("rep05", 1'b1, 1'b0, 1'b1);
        shoot(8'h55);
        check_shot("miss55", 1'b1, 1'b0, 1'b0);
        read_cell(8'h05, 1'b1, 1'b1, "rd05");
        check_shot("idle", 1'b0, 1'b0, 1'b0);
        read_cell(8'h55, 1'b0, 1'b1, "rd55");
        read_cell(8'hAA, 1'b0, 1'b0, "rdAA");

        // Sink the remaining nine ships back to back.
        shot_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            shot_pos = remaining[i];
            cyc();
            check_shot($sformatf("sink%0d", i), 1'b1, 1'b1, 1'b0);
            check($sformatf("sink%0d.sunk", i), {7'd0, all_sunk}, (i == 8) ? 8'd1 : 8'd0);
        end
        shot_valid = 1'b0;

        // After the fleet is destroyed shots still resolve.
        shoot(8'h09);
        check_shot("post09", 1'b1, 1'b0, 1'b1);
        shoot(8'hA0);
        check_shot("postA0", 1'b1, 1'b0, 1'b0);
        check("post.sunk", {7'd0, all_sunk}, 8'd1);
        cyc();
        check_shot("postidle", 1'b0, 1'b0, 1'b0);

        // Fresh game: rejection cases.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rd_pos = 8'h00;
        check_idle_outputs("rst2");

        pick_ship = 1'b1;
        place(8'h23);
        check("p23.count", {4'd0, ship_count}, 8'd1);
        check("p23.perr",  {7'd0, place_err}, 8'd0);
        place(8'h23);
        check("dup23.perr",  {7'd0, place_err}, 8'd1);
        check("dup23.count", {4'd0, ship_count}, 8'd1);
        place(8'hA0);
        check("rowA.perr",  {7'd0, place_err}, 8'd1);
        place(8'h0A);
        check("colA.perr",  {7'd0, place_err}, 8'd1);
        check("colA.count", {4'd0, ship_count}, 8'd1);
        cyc();
        check("errpulse", {7'd0, place_err}, 8'd0);

        // Shot during SETUP on a ship cell: acknowledged, no effect.
        shoot(8'h23);
        check_shot("setup23", 1'b1, 1'b0, 1'b0);
        read_cell(8'h23, 1'b1, 1'b0, "rd23");

        // rst one cycle after an accepted placement, with a shot pending.
        place(8'h11);
        check("p11.count", {4'd0, ship_count}, 8'd2);
        rst = 1'b1;
        shot_valid = 1'b1;
        shot_pos = 8'h11;
        cyc();
        rst = 1'b0;
        shot_valid = 1'b0;
        check("midrst.count", {4'd0, ship_count}, 8'd0);
        check_shot("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.perr", {7'd0, place_err}, 8'd0);
        check("midrst.rship", {7'd0, rd_ship}, 8'd0);
        read_cell(8'h23, 1'b0, 1'b0, "rd23clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
